// File: rtl/ctrl_pkg.sv
// Shared types for the registered control decoder: opcodes, FSM states and the
// control bundle that travels from ID to EX.
package ctrl_pkg;

    localparam int unsigned ALU_OP_W = 3;

    typedef enum logic [3:0] {
        OpAdd  = 4'h0, OpSub  = 4'h1, OpAlu2 = 4'h2, OpAlu3 = 4'h3,
        OpInc  = 4'h4, OpAlu5 = 4'h5, OpAlu6 = 4'h6, OpAlu7 = 4'h7,
        OpLw   = 4'h8, OpSw   = 4'h9, OpLhb  = 4'hA, OpLlb  = 4'hB,
        OpB    = 4'hC, OpCall = 4'hD, OpRet  = 4'hE, OpSys  = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {StRun, StMemWait, StHalted} state_e;

    typedef struct packed {
        logic                valid;
        logic [ALU_OP_W-1:0] alu_op;
        logic                alu_src;
        logic                sign_ext_sel;
        logic                reg_rt_src;
        logic                data_reg;
        logic                stack_reg;
        logic                call;
        logic                rtrn;
        logic                branch;
        logic                mem_to_reg;
        logic                load_half;
        logic                half_spec;
        logic                reg_write;
        logic                mem_write;
        logic                mem_read;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode_seq_if.sv
// Instruction-in / control-out bundle between the IF/ID register, the decoder and EX.
// master drives the instruction side, slave is the decoder.
interface ctrl_decode_seq_if
    import ctrl_pkg::*;
#(
    parameter int unsigned INSTR_W = 16
) ();
    logic                instr_valid;
    logic [INSTR_W-1:0]  instruction;
    logic                stall;
    logic                flush;
    logic                mem_ready;
    logic                instr_ready;
    logic                ctrl_valid;
    logic [ALU_OP_W-1:0] alu_op;
    logic                alu_src, sign_ext_sel, reg_rt_src, data_reg, stack_reg;
    logic                call, rtrn, branch, mem_to_reg, load_half, half_spec;
    logic                RegWrite, MemWrite, MemRead;
    logic                halted, mem_timeout, err_trap;

    modport master (
        output instr_valid, instruction, stall, flush, mem_ready,
        input  instr_ready, ctrl_valid, alu_op, alu_src, sign_ext_sel, reg_rt_src, data_reg,
               stack_reg, call, rtrn, branch, mem_to_reg, load_half, half_spec,
               RegWrite, MemWrite, MemRead, halted, mem_timeout, err_trap
    );

    modport slave (
        input  instr_valid, instruction, stall, flush, mem_ready,
        output instr_ready, ctrl_valid, alu_op, alu_src, sign_ext_sel, reg_rt_src, data_reg,
               stack_reg, call, rtrn, branch, mem_to_reg, load_half, half_spec,
               RegWrite, MemWrite, MemRead, halted, mem_timeout, err_trap
    );
endinterface

// File: rtl/ctrl_decode_comb.sv
// Pure opcode -> control bundle decode; also flags memory ops, HALT and illegal words.
module ctrl_decode_comb
    import ctrl_pkg::*;
#(
    parameter int unsigned INSTR_W = 16
) (
    input  logic [INSTR_W-1:0] instr_i,
    output ctrl_bundle_t       bundle_o,
    output logic               is_mem_o,
    output logic               is_halt_o,
    output logic               is_illegal_o
);
    opcode_e op;
    assign op = opcode_e'(instr_i[INSTR_W-1 -: 4]);

    always_comb begin
        bundle_o     = CTRL_BUBBLE;
        is_mem_o     = 1'b0;
        is_halt_o    = 1'b0;
        is_illegal_o = 1'b0;
        bundle_o.valid = 1'b1;
        unique case (op)
            OpAdd, OpSub, OpAlu2, OpAlu3, OpInc, OpAlu5, OpAlu6, OpAlu7: begin
                bundle_o.alu_op    = op[ALU_OP_W-1:0];
                bundle_o.reg_write = 1'b1;
                bundle_o.alu_src   = (op == OpInc);
            end
            OpLw: begin
                bundle_o.data_reg     = 1'b1;
                bundle_o.alu_src      = 1'b1;
                bundle_o.sign_ext_sel = 1'b1;
                bundle_o.mem_to_reg   = 1'b1;
                bundle_o.mem_read     = 1'b1;
                bundle_o.reg_write    = 1'b1;
                is_mem_o              = 1'b1;
            end
            OpSw: begin
                bundle_o.data_reg     = 1'b1;
                bundle_o.alu_src      = 1'b1;
                bundle_o.sign_ext_sel = 1'b1;
                bundle_o.reg_rt_src   = 1'b1;
                bundle_o.mem_write    = 1'b1;
                is_mem_o              = 1'b1;
            end
            OpLhb, OpLlb: begin
                bundle_o.reg_rt_src = 1'b1;
                bundle_o.load_half  = 1'b1;
                bundle_o.reg_write  = 1'b1;
                bundle_o.half_spec  = (op == OpLlb);
            end
            OpB: begin
                bundle_o.branch       = 1'b1;
                bundle_o.sign_ext_sel = 1'b1;
            end
            OpCall: begin
                bundle_o.stack_reg = 1'b1;
                bundle_o.call      = 1'b1;
                bundle_o.mem_write = 1'b1;
                bundle_o.reg_write = 1'b1;
                is_mem_o           = 1'b1;
            end
            OpRet: begin
                bundle_o.stack_reg = 1'b1;
                bundle_o.rtrn      = 1'b1;
                bundle_o.mem_read  = 1'b1;
                bundle_o.reg_write = 1'b1;
                is_mem_o           = 1'b1;
            end
            OpSys: begin
                // Only the all-ones word is HALT; every other 1111 word decodes as a bubble.
                is_halt_o      = &instr_i;
                is_illegal_o   = ~&instr_i;
                bundle_o.valid = &instr_i;
            end
            default: bundle_o = CTRL_BUBBLE;
        endcase
    end
endmodule

// File: rtl/ctrl_decode_seq.sv
// Registered, stall-aware control decoder with memory-wait sequencing and sticky HALT.
// Optional: define CTRL_ERR_TRAP_EN to pulse err_trap on illegal 1111 words.
module ctrl_decode_seq
    import ctrl_pkg::*;
#(
    parameter int unsigned INSTR_W  = 16,
    parameter int unsigned WAIT_MAX = 15
) (
    input logic              clk,
    input logic              rst,
    ctrl_decode_seq_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WAIT_MAX + 1);

    ctrl_bundle_t dec_bundle, bundle_d, bundle_q;
    logic         dec_is_mem, dec_is_halt, dec_is_illegal;
    state_e       state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic         halted_d, halted_q, timeout_d, timeout_q, err_d;
    logic         ready;

    ctrl_decode_comb #(.INSTR_W(INSTR_W)) u_decode (
        .instr_i      (bus.instruction),
        .bundle_o     (dec_bundle),
        .is_mem_o     (dec_is_mem),
        .is_halt_o    (dec_is_halt),
        .is_illegal_o (dec_is_illegal)
    );

    assign ready = (state_q == StRun) && !bus.stall && !bus.flush;

    always_comb begin
        state_d   = state_q;
        bundle_d  = bundle_q;
        cnt_d     = cnt_q;
        halted_d  = halted_q;
        timeout_d = timeout_q;
        err_d     = 1'b0;
        unique case (state_q)
            StRun: begin
                if (bus.flush) begin
                    bundle_d = CTRL_BUBBLE;
                    cnt_d    = '0;
                end else if (!bus.stall) begin
                    bundle_d = CTRL_BUBBLE;
                    if (bus.instr_valid) begin
                        bundle_d = dec_bundle;
                        if (dec_is_halt) begin
                            state_d  = StHalted;
                            halted_d = 1'b1;
                        end else if (dec_is_mem) begin
                            state_d = StMemWait;
                            cnt_d   = '0;
                        end else if (dec_is_illegal) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            StMemWait: begin
                // The counter keeps running under stall, so a stalled access can still time out.
                if (bus.flush || bus.mem_ready || cnt_q == CNT_W'(WAIT_MAX - 1)) begin
                    timeout_d = timeout_q | (!bus.flush && !bus.mem_ready);
                    bundle_d  = CTRL_BUBBLE;
                    state_d   = StRun;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHalted: bundle_d = CTRL_BUBBLE;
            default: begin
                state_d  = StRun;
                bundle_d = CTRL_BUBBLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StRun;
            bundle_q  <= CTRL_BUBBLE;
            cnt_q     <= '0;
            halted_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bundle_q  <= bundle_d;
            cnt_q     <= cnt_d;
            halted_q  <= halted_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef CTRL_ERR_TRAP_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end
    assign bus.err_trap = err_q;
`else
    logic unused_err;
    assign unused_err   = err_d;
    assign bus.err_trap = 1'b0;
`endif

    assign bus.instr_ready  = ready;
    assign bus.ctrl_valid   = bundle_q.valid;
    assign bus.alu_op       = bundle_q.alu_op;
    assign bus.alu_src      = bundle_q.alu_src;
    assign bus.sign_ext_sel = bundle_q.sign_ext_sel;
    assign bus.reg_rt_src   = bundle_q.reg_rt_src;
    assign bus.data_reg     = bundle_q.data_reg;
    assign bus.stack_reg    = bundle_q.stack_reg;
    assign bus.call         = bundle_q.call;
    assign bus.rtrn         = bundle_q.rtrn;
    assign bus.branch       = bundle_q.branch;
    assign bus.mem_to_reg   = bundle_q.mem_to_reg;
    assign bus.load_half    = bundle_q.load_half;
    assign bus.half_spec    = bundle_q.half_spec;
    assign bus.RegWrite     = bundle_q.reg_write;
    assign bus.MemWrite     = bundle_q.mem_write;
    assign bus.MemRead      = bundle_q.mem_read;
    assign bus.halted       = halted_q;
    assign bus.mem_timeout  = timeout_q;
endmodule

// File: tb/tb_ctrl_decode_seq.sv
// Scoreboard bench for ctrl_decode_seq: driver queues expected ready/outputs, monitor compares.
module tb_ctrl_decode_seq;
    import ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ctrl_decode_seq_if #(.INSTR_W(16)) bus ();

    ctrl_decode_seq #(.INSTR_W(16), .WAIT_MAX(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic         ready;
        ctrl_bundle_t b;
        logic         h;
        logic         to;
        logic         er;
    } item_t;

    item_t q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    n_item  = 0;

    ctrl_bundle_t bub, e_sub, e_add, e_inc, e_lhb, e_llb, e_lw, e_sw, e_b, e_call, e_ret, e_halt;
    logic         exp_err;

    function automatic ctrl_bundle_t actual();
        ctrl_bundle_t a;
        a.valid = bus.ctrl_valid;       a.alu_op = bus.alu_op;
        a.alu_src = bus.alu_src;        a.sign_ext_sel = bus.sign_ext_sel;
        a.reg_rt_src = bus.reg_rt_src;  a.data_reg = bus.data_reg;
        a.stack_reg = bus.stack_reg;    a.call = bus.call;
        a.rtrn = bus.rtrn;              a.branch = bus.branch;
        a.mem_to_reg = bus.mem_to_reg;  a.load_half = bus.load_half;
        a.half_spec = bus.half_spec;    a.reg_write = bus.RegWrite;
        a.mem_write = bus.MemWrite;     a.mem_read = bus.MemRead;
        return a;
    endfunction

    // Monitor: instr_ready checked mid-cycle, registered outputs just after the edge.
    initial begin
        item_t it;
        logic [20:0] act, exp;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                it = q.pop_front();
                n_item++;
                n_tests++;
                if (bus.instr_ready !== it.ready) begin
                    n_fail++;
                    $display("FAIL ready#%0d: got %b want %b", n_item, bus.instr_ready, it.ready);
                end
                @(posedge clk);
                #1;
                act = {actual(), bus.halted, bus.mem_timeout, bus.err_trap};
                exp = {it.b, it.h, it.to, it.er};
                n_tests++;
                if (act !== exp) begin
                    n_fail++;
                    $display("FAIL out#%0d: got %h want %h", n_item, act, exp);
                end
            end
        end
    end

    task automatic cyc(input logic r, input logic v, input logic [15:0] ins, input logic st,
                       input logic fl, input logic mr, input logic e_rdy, input ctrl_bundle_t eb,
                       input logic eh, input logic eto, input logic eer);
        item_t it;
        rst             = r;
        bus.instr_valid = v;
        bus.instruction = ins;
        bus.stall       = st;
        bus.flush       = fl;
        bus.mem_ready   = mr;
        it.ready = e_rdy; it.b = eb; it.h = eh; it.to = eto; it.er = eer;
        q.push_back(it);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bub = CTRL_BUBBLE;
        e_sub = bub;  e_sub.valid = 1;  e_sub.alu_op = 3'd1;  e_sub.reg_write = 1;
        e_add = bub;  e_add.valid = 1;  e_add.reg_write = 1;
        e_inc = e_add; e_inc.alu_op = 3'd4; e_inc.alu_src = 1;
        e_lhb = bub;  e_lhb.valid = 1;  e_lhb.reg_rt_src = 1; e_lhb.load_half = 1;
        e_lhb.reg_write = 1;
        e_llb = e_lhb; e_llb.half_spec = 1;
        e_lw = bub;   e_lw.valid = 1;   e_lw.data_reg = 1; e_lw.alu_src = 1;
        e_lw.sign_ext_sel = 1; e_lw.mem_to_reg = 1; e_lw.mem_read = 1; e_lw.reg_write = 1;
        e_sw = bub;   e_sw.valid = 1;   e_sw.data_reg = 1; e_sw.alu_src = 1;
        e_sw.sign_ext_sel = 1; e_sw.reg_rt_src = 1; e_sw.mem_write = 1;
        e_b = bub;    e_b.valid = 1;    e_b.branch = 1; e_b.sign_ext_sel = 1;
        e_call = bub; e_call.valid = 1; e_call.stack_reg = 1; e_call.call = 1;
        e_call.mem_write = 1; e_call.reg_write = 1;
        e_ret = bub;  e_ret.valid = 1;  e_ret.stack_reg = 1; e_ret.rtrn = 1;
        e_ret.mem_read = 1; e_ret.reg_write = 1;
        e_halt = bub; e_halt.valid = 1;
`ifdef CTRL_ERR_TRAP_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        bus.instr_valid = 0; bus.instruction = '0; bus.stall = 0; bus.flush = 0;
        bus.mem_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        //   rst v  instr     st fl mr rdy bundle  h  to err
        cyc(0, 0, 16'h0000, 0, 0, 0, 1, bub,    0, 0, 0);   // reset state
        cyc(0, 1, 16'h1234, 0, 0, 0, 1, e_sub,  0, 0, 0);
        cyc(0, 1, 16'h4500, 0, 0, 0, 1, e_inc,  0, 0, 0);
        cyc(0, 1, 16'hA0FF, 0, 0, 0, 1, e_lhb,  0, 0, 0);
        cyc(0, 1, 16'hB0FF, 0, 0, 0, 1, e_llb,  0, 0, 0);
        cyc(0, 1, 16'h0000, 1, 0, 0, 0, e_llb,  0, 0, 0);   // stall holds
        cyc(0, 1, 16'h0000, 1, 0, 0, 0, e_llb,  0, 0, 0);
        cyc(0, 1, 16'h0000, 0, 0, 0, 1, e_add,  0, 0, 0);
        cyc(0, 0, 16'h0000, 0, 0, 0, 1, bub,    0, 0, 0);
        cyc(0, 1, 16'hC000, 0, 0, 0, 1, e_b,    0, 0, 0);
        cyc(0, 1, 16'hD000, 0, 0, 0, 1, e_call, 0, 0, 0);
        cyc(0, 1, 16'h1234, 0, 0, 1, 0, bub,    0, 0, 0);   // CALL completes
        cyc(0, 1, 16'hE000, 0, 0, 0, 1, e_ret,  0, 0, 0);
        cyc(0, 0, 16'h0000, 1, 0, 1, 0, bub,    0, 0, 0);   // completes under stall
        cyc(0, 1, 16'h8123, 0, 0, 0, 1, e_lw,   0, 0, 0);
        repeat (3) cyc(0, 0, 16'h0000, 0, 0, 0, 0, e_lw, 0, 0, 0);
        cyc(0, 0, 16'h0000, 0, 0, 1, 0, bub,    0, 0, 0);
        cyc(0, 0, 16'h0000, 0, 0, 0, 1, bub,    0, 0, 0);
        cyc(0, 1, 16'h1234, 0, 0, 1, 1, e_sub,  0, 0, 0);   // mem_ready ignored in RUN
        cyc(0, 1, 16'h4500, 0, 0, 0, 1, e_inc,  0, 0, 0);
        cyc(0, 1, 16'h1234, 1, 1, 0, 0, bub,    0, 0, 0);   // flush beats stall
        cyc(0, 1, 16'h4500, 0, 0, 0, 1, e_inc,  0, 0, 0);
        cyc(0, 1, 16'h4500, 0, 1, 0, 0, bub,    0, 0, 0);
        cyc(0, 1, 16'h8123, 0, 0, 0, 1, e_lw,   0, 0, 0);
        cyc(0, 0, 16'h0000, 0, 1, 0, 0, bub,    0, 0, 0);   // flush in MEM_WAIT
        cyc(0, 0, 16'h0000, 0, 0, 0, 1, bub,    0, 0, 0);
        cyc(0, 1, 16'hF0F0, 0, 0, 0, 1, bub,    0, 0, exp_err);
        cyc(0, 0, 16'h0000, 0, 0, 0, 1, bub,    0, 0, 0);
        cyc(0, 1, 16'h9123, 0, 0, 0, 1, e_sw,   0, 0, 0);
        repeat (12) cyc(0, 0, 16'h0000, 0, 0, 0, 0, e_sw, 0, 0, 0);
        repeat (2) cyc(0, 0, 16'h0000, 1, 0, 0, 0, e_sw, 0, 0, 0);
        cyc(0, 0, 16'h0000, 1, 0, 0, 0, bub,    0, 1, 0);   // timeout fires under stall
        cyc(0, 0, 16'h0000, 0, 0, 0, 1, bub,    0, 1, 0);
        cyc(0, 1, 16'hFFFF, 0, 1, 0, 0, bub,    0, 1, 0);   // HALT with flush discarded
        cyc(0, 0, 16'h0000, 0, 0, 0, 1, bub,    0, 1, 0);
        cyc(0, 1, 16'hFFFF, 0, 0, 0, 1, e_halt, 1, 1, 0);
        cyc(0, 1, 16'h1234, 0, 0, 0, 0, bub,    1, 1, 0);
        cyc(0, 1, 16'h1234, 0, 1, 0, 0, bub,    1, 1, 0);
        cyc(0, 0, 16'h0000, 0, 0, 0, 0, bub,    1, 1, 0);
        cyc(1, 0, 16'h0000, 0, 0, 0, 0, bub,    0, 0, 0);   // only rst leaves HALTED
        cyc(0, 0, 16'h0000, 0, 0, 0, 1, bub,    0, 0, 0);
        cyc(0, 1, 16'h1234, 0, 0, 0, 1, e_sub,  0, 0, 0);
        cyc(0, 0, 16'h0000, 0, 0, 0, 1, bub,    0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
